// File: rtl/isqrt_fsm.sv
// Multi-cycle integer square root: floor(sqrt(x)) for a 32-bit radicand using a
// restoring digit-by-digit datapath, with a one-entry pending buffer in front.
module isqrt_fsm #(
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y,
   output logic        busy,
   output logic        overflow
);

   // Handshake: x_vld is a one-cycle request strobe with no ready; the block
   // never stalls the initiator. A request arriving while both the datapath and
   // the pending entry are occupied is dropped and sets the sticky overflow.
   // y_vld is a one-cycle strobe; y holds its value until the next result.

   localparam int N  = 16 / STEPS_PER_CYCLE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] CALC = 1'b1;

   if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4 ||
         STEPS_PER_CYCLE == 8 || STEPS_PER_CYCLE == 16)) begin : g_bad_steps
      $error("isqrt_fsm: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   logic [0:0]    state;
   logic [17:0]   rem;
   logic [15:0]   root;
   logic [31:0]   rad;
   logic [CW-1:0] cnt;
   logic          pend_full;
   logic [31:0]   pend;

   logic [17:0]   rem_nxt;
   logic [15:0]   root_nxt;
   logic [31:0]   rad_nxt;

   // Unrolled restoring steps; the working remainder is 20 bits so the shifted
   // value and the trial divisor are compared without truncation.
   always_comb begin : p_steps
      logic [19:0] r_w;
      logic [19:0] trial;
      logic [17:0] r_acc;
      logic [15:0] q_acc;
      r_w   = '0;
      trial = '0;
      r_acc = rem;
      q_acc = root;
      for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
         r_w   = {r_acc, rad[31-2*i -: 2]};
         trial = {2'b00, q_acc, 2'b01};
         if (r_w >= trial) begin
            r_acc = r_w[17:0] - trial[17:0];
            q_acc = {q_acc[14:0], 1'b1};
         end else begin
            r_acc = r_w[17:0];
            q_acc = {q_acc[14:0], 1'b0};
         end
      end
      rem_nxt  = r_acc;
      root_nxt = q_acc;
      rad_nxt  = rad << (2 * STEPS_PER_CYCLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         root      <= '0;
         rad       <= '0;
         cnt       <= '0;
         pend_full <= 1'b0;
         pend      <= '0;
         y_vld     <= 1'b0;
         y         <= '0;
         overflow  <= 1'b0;
      end else begin
         y_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (x_vld) begin
                  rem   <= '0;
                  root  <= '0;
                  rad   <= x;
                  cnt   <= CW'(N - 1);
                  state <= CALC;
               end
            end
            CALC: begin
               rem  <= rem_nxt;
               root <= root_nxt;
               rad  <= rad_nxt;
               cnt  <= cnt - 1'b1;
               if (cnt == '0) begin
                  y     <= root_nxt;
                  y_vld <= 1'b1;
                  // Final cycle: the pending entry has priority, a new strobe
                  // refills the entry so nothing is lost.
                  if (pend_full) begin
                     rem       <= '0;
                     root      <= '0;
                     rad       <= pend;
                     cnt       <= CW'(N - 1);
                     pend_full <= x_vld;
                     if (x_vld) pend <= x;
                  end else if (x_vld) begin
                     rem  <= '0;
                     root <= '0;
                     rad  <= x;
                     cnt  <= CW'(N - 1);
                  end else begin
                     state <= IDLE;
                  end
               end else if (x_vld) begin
                  if (!pend_full) begin
                     pend      <= x;
                     pend_full <= 1'b1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == CALC) | pend_full;

endmodule

// File: tb/tb_isqrt_fsm.sv
// Bench for isqrt_fsm: three instances (1, 4 and 16 steps per cycle) share one
// request stream; a queue-level occupancy model predicts results, timing, busy and overflow.
module tb_isqrt_fsm;

   logic        clk;
   logic        rst;
   logic        x_vld;
   logic [31:0] x;

   logic        y_vld_a    [3];
   logic [15:0] y_a        [3];
   logic        busy_a     [3];
   logic        overflow_a [3];

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   logic [47:0] exp_q0[$];
   logic [47:0] exp_q1[$];
   logic [47:0] exp_q2[$];

   int          last_end    [3];
   int          prev_end    [3];
   int          chain_start [3];
   int          drop_cyc    [3];
   logic [15:0] last_y      [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      isqrt_fsm #(.STEPS_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 4 : 16))) u_dut (
         .clk      (clk),
         .rst      (rst),
         .x_vld    (x_vld),
         .x        (x),
         .y_vld    (y_vld_a[g]),
         .y        (y_a[g]),
         .busy     (busy_a[g]),
         .overflow (overflow_a[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int spc(input int k);
      case (k)
         0:       return 1;
         1:       return 4;
         default: return 16;
      endcase
   endfunction

   function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
      longint vv, lo, hi, mid;
      vv = longint'({32'd0, v});
      lo = 0;
      hi = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= vv) lo = mid;
         else hi = mid - 1;
      end
      return lo[15:0];
   endfunction

   task automatic push_exp(input int k, input logic [47:0] e);
      case (k)
         0:       exp_q0.push_back(e);
         1:       exp_q1.push_back(e);
         default: exp_q2.push_back(e);
      endcase
   endtask

   function automatic int q_size(input int k);
      case (k)
         0:       return exp_q0.size();
         1:       return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   task automatic pop_exp(input int k, output logic [47:0] e);
      case (k)
         0:       e = exp_q0.pop_front();
         1:       e = exp_q1.pop_front();
         default: e = exp_q2.pop_front();
      endcase
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         last_end[k]    = -1000;
         prev_end[k]    = -1000;
         chain_start[k] = -1000;
         drop_cyc[k]    = -1;
         last_y[k]      = '0;
      end
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
   endtask

   task automatic check(input string name, input int k, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d(steps=%0d) cyc=%0d got=%0h exp=%0h",
                  name, k, spc(k), cyc, got, exp);
      end
   endtask

   // Monitor: compares every instance every cycle against the model.
   task automatic check_dut(input int k);
      logic [47:0] e;
      logic        exp_busy;
      logic        exp_ovf;
      if (y_vld_a[k]) begin
         if (q_size(k) == 0) begin
            check("unexpected_y_vld", k, 32'd1, 32'd0);
         end else begin
            pop_exp(k, e);
            check("y_value", k, {16'd0, y_a[k]}, {16'd0, e[15:0]});
            check("y_cycle", k, cyc, e[47:16]);
            last_y[k] = e[15:0];
         end
      end else begin
         check("y_hold", k, {16'd0, y_a[k]}, {16'd0, last_y[k]});
      end
      exp_busy = (cyc > chain_start[k]) && (cyc <= last_end[k]);
      exp_ovf  = (drop_cyc[k] >= 0) && (cyc > drop_cyc[k]);
      check("busy", k, {31'd0, busy_a[k]}, {31'd0, exp_busy});
      check("overflow", k, {31'd0, overflow_a[k]}, {31'd0, exp_ovf});
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) check_dut(k);
   end

   // A request is accepted unless two jobs (one computing, one pending) are
   // still unfinished at this cycle; accepted jobs run back to back, N cycles each.
   task automatic issue(input logic [31:0] v);
      int t;
      int n;
      int outstanding;
      t = cyc;
      x_vld = 1'b1;
      x = v;
      for (int k = 0; k < 3; k++) begin
         n = 16 / spc(k);
         outstanding = ((last_end[k] > t) ? 1 : 0) + ((prev_end[k] > t) ? 1 : 0);
         if (outstanding < 2) begin
            if (last_end[k] < t) chain_start[k] = t;
            prev_end[k] = last_end[k];
            last_end[k] = ((last_end[k] > t) ? last_end[k] : t) + n;
            push_exp(k, {32'(last_end[k] + 1), ref_isqrt(v)});
         end else if (drop_cyc[k] < 0) begin
            drop_cyc[k] = t;
         end
      end
      @(posedge clk);
      #1;
      x_vld = 1'b0;
      x = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      x_vld = 1'b0;
      model_reset();
      idle(2);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] bvals [5];
      logic [31:0] v;
      int          r;
      bvals[0] = 32'd0;
      bvals[1] = 32'd1;
      bvals[2] = 32'd15;
      bvals[3] = 32'd16;
      bvals[4] = 32'hFFFF_FFFF;
      rst = 1'b1;
      x_vld = 1'b0;
      x = '0;
      model_reset();
      idle(2);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 5; i++) begin
         issue(bvals[i]);
         idle(20);
      end

      issue(32'd100);
      idle(4);
      issue(32'd81);
      idle(40);

      issue(32'd4);
      idle(2);
      issue(32'd9);
      idle(2);
      issue(32'd25);
      idle(40);

      do_reset();
      issue(32'd49);
      idle(7);
      do_reset();
      idle(30);

      issue(32'd1000000);
      idle(10);
      repeat (8) begin
         issue($urandom);
         idle(3);
      end
      idle(40);

      do_reset();
      for (int i = 0; i < 10000; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0) v = 32'hFFFF_FFFF;
         else if (r == 1) v = 32'($urandom_range(0, 20));
         else v = $urandom;
         issue(v);
         idle($urandom_range(0, 10));
      end
      idle(40);

      for (int k = 0; k < 3; k++) check("results_drained", k, 32'(q_size(k)), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
